fetch: RTL and testbench
========================

Name: fetch

Overview:
Instruction fetch stage that sits directly upstream of decode and drives its instruction input (ir_o to decode ir_i).
- Owns the program counter.
- Issues word requests to instruction memory over a request/grant interface with in-order responses.
- Buffers returned instructions in a small FIFO.
- Presents them to decode with a valid/ready handshake.
- Squashes in-flight and buffered instructions on a redirect (branch or jump).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, instruction FIFO entries and maximum outstanding requests; power of two, ≥2.
NOP, 32'h0000_0013, instruction presented on ir_o when the FIFO is empty (ADDI x0,x0,0).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
imem_req_o  output  1  fetch request valid.
imem_addr_o  output  32  fetch byte address; always word aligned.
imem_gnt_i  input  1  request accepted this cycle.
imem_rvalid_i  input  1  response data valid; responses return in grant order, ≥1 cycle after grant.
imem_rdata_i  input  32  response instruction word.
redirect_i  input  1  flush and restart fetch.
redirect_pc_i  input  32  new PC; bits [1:0] ignored and treated as 00.
ir_o  output  32  instruction to decode.
pc_o  output  32  PC of the ir_o instruction.
valid_o  output  1  ir_o/pc_o hold a live instruction.
ready_i  input  1  decode accepts ir_o this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC; FIFO empty; outstanding=0; discard=0; state=BOOT.
  - imem_req_o=0, valid_o=0, ir_o=NOP, pc_o=0.
- States:
  - BOOT: one cycle after reset release, no request; goes to RUN.
  - RUN: normal fetch.
  - FLUSH: waits for discarded responses to drain.
- Request rule (RUN only):
  - imem_req_o=1 when outstanding + fifo_count < DEPTH.
  - imem_addr_o=pc.
  - Request and address stay stable until granted unless redirect_i fires.
- Grant (req & gnt):
  - outstanding+1; pc <= pc+4, wrapping modulo 2^32.
  - The FIFO also records pc for pc_o.
- Response (rvalid):
  - If discard>0: discard-1, data dropped.
  - Otherwise outstanding-1 and {pc, rdata} is pushed.
  - The credit rule guarantees no push into a full FIFO.
- Output:
  - valid_o = FIFO non-empty; ir_o/pc_o = head entry.
  - When empty, ir_o=NOP and pc_o holds its last value.
  - Outputs are registered from FIFO storage; no combinational path from imem_rdata_i to ir_o.
- Pop: valid_o & ready_i. Push and pop in the same cycle are allowed, and the count is unchanged.
- Latency: grant at cycle N, rvalid at N+k gives valid_o at N+k+1.
- Redirect (takes priority over everything in the same cycle):
  - FIFO cleared and the pop is ignored (decode still treats the cycle as consumed).
  - pc <= {redirect_pc_i[31:2],2'b00}.
  - discard <= outstanding + (req & gnt this cycle) − (rvalid this cycle and not already discarded); i.e. every response still owed is dropped.
  - If the new discard > 0, go to FLUSH, else RUN.
  - imem_req_o is 0 in the redirect cycle's following state only if in FLUSH.
- FLUSH:
  - No requests; go to RUN in the cycle after discard reaches 0.
  - A redirect while in FLUSH reloads pc and stays in FLUSH.
- rvalid with outstanding=0 and discard=0: ignored, no state change.
- Reset mid-operation: all state cleared immediately. Responses arriving after reset release are ignored under the rule above.

Decomposition:
- Shared package: NOP encoding, reset PC, opcode/field constants already needed by decode (rs1/rs2 bit positions).
- One sub-module is natural: fetch_fifo, a DEPTH-entry synchronous FIFO of {pc,instr} with push, pop, clear, count, head outputs, and the same async active-low reset.
- Counters and the FSM stay in fetch.

Test Plan:
- Reset release, memory grants every cycle, response 1 cycle later, ready_i=1 → addresses 0x0,0x4,0x8… issued; valid_o first rises 3 cycles after reset release with ir_o=word@0x0, pc_o=0x0.
- ready_i=0 with 2 grants returned → FIFO full, imem_req_o=0. Raising ready_i → entries pop in order 0x0 then 0x4, and a new request appears the following cycle.
- Redirect to 0x0000_0103 while 2 requests are outstanding → imem_addr_o=0x100 after FLUSH; exactly 2 responses dropped; first valid_o shows pc_o=0x100.
- Redirect in the same cycle as a grant and an rvalid → granted request discarded, rvalid data dropped, no stale instruction ever reaches valid_o.
- pc=0xFFFF_FFFC granted → next imem_addr_o=0x0000_0000 (wrap).
- Assert reset mid-stream with FIFO full → valid_o=0, ir_o=0x0000_0013, imem_req_o=0 asynchronously. After release, a late stray rvalid is ignored and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module  : fetch_pkg
// Purpose : Shared constants and types for the instruction fetch stage and
//           the decode stage it feeds.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    // ADDI x0,x0,0 -- shown to decode whenever no instruction is buffered
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction field positions shared with decode
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;

    // Major opcodes decode needs to recognise
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Fetch control states
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    // Redirect targets are forced onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module  : fetch_fifo
// Purpose : DEPTH-entry synchronous FIFO of {pc, instruction} pairs with a
//           synchronous clear. Head entry is read straight from storage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_ir,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              head_pc,
    output logic [31:0]              head_ir
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   ir_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Clear wins over both push and pop; popping an empty FIFO is a no-op
    assign do_push = push & ~clear;
    assign do_pop  = pop & ~clear & (count != '0);

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as live
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr] <= push_pc;
            ir_mem[wr_ptr] <= push_ir;
        end
    end

    assign head_pc = pc_mem[rd_ptr];
    assign head_ir = ir_mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// ============================================================================
// Module  : fetch
// Purpose : Instruction fetch stage. Owns the PC, issues credit-limited word
//           requests to instruction memory, buffers in-order responses and
//           hands them to decode; redirects squash everything still owed.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ir_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic [31:0]   pc;
    logic [31:0]   pc_next;
    logic [31:0]   last_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_next;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic          grant;
    logic          rv_drop;
    logic          rv_take;
    logic          push;
    logic          pop;
    logic [31:0]   push_pc;
    logic [31:0]   head_pc;
    logic [31:0]   head_ir;

    // Every requested word needs a FIFO slot reserved, so requests in flight
    // plus buffered entries may never exceed DEPTH.
    assign credit_used = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_o  = (state == ST_RUN) && (credit_used < DEPTH_W);
    assign imem_addr_o = pc;
    assign grant       = imem_req_o & imem_gnt_i;

    // Responses owed from before a redirect are consumed first; a response
    // with nothing owed at all is a stray and is ignored.
    assign rv_drop = imem_rvalid_i && (discard != '0);
    assign rv_take = imem_rvalid_i && (discard == '0) && (outstanding != '0);
    assign push    = rv_take & ~redirect_i;
    assign pop     = valid_o & ready_i & ~redirect_i;

    // Responses are in order and live requests are sequential, so the oldest
    // live response belongs to the PC that many words behind the current one.
    assign push_pc = pc - 32'({outstanding, 2'b00});

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_pc (push_pc),
        .push_ir (imem_rdata_i),
        .pop     (pop),
        .clear   (redirect_i),
        .count   (count),
        .head_pc (head_pc),
        .head_ir (head_ir)
    );

    // Next-state, PC and counter logic; redirect overrides everything else
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        outstanding_next = outstanding;
        discard_next     = discard;

        if (grant) pc_next = pc + 32'd4;

        if (grant && !rv_take)      outstanding_next = outstanding + CW'(1);
        else if (!grant && rv_take) outstanding_next = outstanding - CW'(1);

        if (rv_drop) discard_next = discard - CW'(1);

        case (state)
            ST_BOOT:  state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            ST_FLUSH: state_next = (discard_next == '0) ? ST_RUN : ST_FLUSH;
            default:  state_next = ST_BOOT;
        endcase

        if (redirect_i) begin
            pc_next          = word_align(redirect_pc_i);
            outstanding_next = '0;
            // Everything still owed, including a grant landing this cycle,
            // becomes a response to throw away.
            discard_next     = discard - CW'(rv_drop) + outstanding
                               + CW'(grant) - CW'(rv_take);
            state_next       = (discard_next != '0) ? ST_FLUSH : ST_RUN;
        end
    end

    // State, PC and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
        end
    end

    // Remember the last presented PC so pc_o holds steady while empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_pc <= '0;
        end else if (valid_o) begin
            last_pc <= head_pc;
        end
    end

    assign valid_o = (count != '0);
    assign ir_o    = valid_o ? head_ir : NOP;
    assign pc_o    = valid_o ? head_pc : last_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// ============================================================================
// Module  : tb_fetch
// Purpose : Self-checking bench for fetch: memory responder with random
//           grant/latency, transaction-level model of what decode must see.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch;
    import fetch_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .NOP(NOP_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i)
    );

    // Request the memory still owes: address it was asked for, the PC the
    // model expected there, whether a redirect has orphaned it, and when due.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] epc;
        bit          stale;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] live_q[$];     // PCs decode should see next, oldest first
    logic [31:0] exp_addr;
    logic [31:0] last_pc;
    bit          boot;
    int          cyc;
    int          n_vec = 0;
    int          n_err = 0;

    int          gnt_pct, rdy_pct, rv_pct, redir_pct, stray_pct, lat_min, lat_max;
    bit          redir_now;
    logic [31:0] redir_tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic int count_pend(input bit want_stale);
        int n = 0;
        foreach (pend_q[i]) if (pend_q[i].stale == want_stale) n++;
        return n;
    endfunction

    task automatic idle_inputs();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        ready_i       = 1'b0;
    endtask

    task automatic set_knobs(input int g, input int r, input int rv, input int lmin, input int lmax);
        gnt_pct = g; rdy_pct = r; rv_pct = rv; lat_min = lmin; lat_max = lmax;
        redir_pct = 0; stray_pct = 0; redir_now = 1'b0;
    endtask

    // Holds reset low for two edges (reset must already be low), then
    // releases it mid-cycle and restarts the model.
    task automatic release_reset();
        repeat (2) @(posedge clk);
        #3;
        pend_q.delete();
        live_q.delete();
        exp_addr = RST_PC;
        last_pc  = '0;
        boot     = 1'b1;
        cyc      = 0;
        reset    = 1'b1;
    endtask

    // One clock: check outputs against the model, drive this cycle's inputs,
    // advance the model, then move to just after the next rising edge.
    task automatic run_cycle();
        bit          exp_req, do_gnt, do_rv, do_rdy, do_redir, granted, was_valid;
        logic [31:0] tgt;
        pend_t       h;
        int          lat;

        exp_req = !boot && (count_pend(1'b1) == 0) &&
                  (count_pend(1'b0) + live_q.size() < DEPTH);
        n_vec++;
        if (imem_req_o !== exp_req) begin
            n_err++;
            $display("FAIL req cyc=%0d got=%b exp=%b", cyc, imem_req_o, exp_req);
        end
        if (exp_req) begin
            n_vec++;
            if (imem_addr_o !== exp_addr) begin
                n_err++;
                $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, imem_addr_o, exp_addr);
            end
        end
        was_valid = (live_q.size() != 0);
        n_vec++;
        if (valid_o !== was_valid) begin
            n_err++;
            $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid_o, was_valid);
        end
        if (was_valid) begin
            n_vec++;
            if (pc_o !== live_q[0] || ir_o !== mem_word(live_q[0])) begin
                n_err++;
                $display("FAIL head cyc=%0d got pc=%h ir=%h exp pc=%h ir=%h",
                         cyc, pc_o, ir_o, live_q[0], mem_word(live_q[0]));
            end
        end else begin
            n_vec++;
            if (ir_o !== NOP_W || pc_o !== last_pc) begin
                n_err++;
                $display("FAIL empty cyc=%0d got pc=%h ir=%h exp pc=%h ir=%h",
                         cyc, pc_o, ir_o, last_pc, NOP_W);
            end
        end

        do_gnt   = ($urandom % 100) < gnt_pct;
        do_rdy   = ($urandom % 100) < rdy_pct;
        do_redir = redir_now || (($urandom % 100) < redir_pct);
        tgt      = redir_now ? redir_tgt :
                   (($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom);
        redir_now = 1'b0;
        do_rv    = (pend_q.size() != 0) && (pend_q[0].due <= cyc) && (($urandom % 100) < rv_pct);
        granted  = (imem_req_o === 1'b1) && do_gnt;
        lat      = $urandom_range(lat_max, lat_min);

        imem_gnt_i    = do_gnt;
        ready_i       = do_rdy;
        redirect_i    = do_redir;
        redirect_pc_i = tgt;
        if (do_rv) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend_q[0].addr);
        end else if (pend_q.size() == 0 && (($urandom % 100) < stray_pct)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = $urandom;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end

        if (was_valid) last_pc = live_q[0];
        if (do_rv) h = pend_q.pop_front();
        if (do_redir) begin
            live_q.delete();
            if (granted) pend_q.push_back('{addr: imem_addr_o, epc: exp_addr, stale: 1'b1, due: cyc + lat});
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_addr = {tgt[31:2], 2'b00};
        end else begin
            if (was_valid && do_rdy) void'(live_q.pop_front());
            if (do_rv && !h.stale) live_q.push_back(h.epc);
            if (granted) begin
                pend_q.push_back('{addr: imem_addr_o, epc: exp_addr, stale: 1'b0, due: cyc + lat});
                exp_addr = exp_addr + 32'd4;
            end
        end
        boot = 1'b0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        set_knobs(0, 0, 100, 1, 1);
        reset = 1'b0;
        idle_inputs();
        #1;
        n_vec++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || ir_o !== NOP_W || pc_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs got req=%b valid=%b ir=%h pc=%h exp 0/0/%h/0",
                     imem_req_o, valid_o, ir_o, pc_o, NOP_W);
        end
        release_reset();
        n_vec++;
        if (imem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL boot_no_req got=%b exp=0", imem_req_o);
        end
        run_cycle();
        n_vec++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC) begin
            n_err++;
            $display("FAIL first_req got req=%b addr=%h exp 1/%h", imem_req_o, imem_addr_o, RST_PC);
        end
    endtask

    task automatic test_stream();
        int          first = -1;
        logic [31:0] fpc = 'x, fir = 'x;
        set_knobs(100, 100, 100, 1, 1);
        reset = 1'b0; idle_inputs();
        release_reset();
        for (int i = 0; i < 14; i++) begin
            if (valid_o === 1'b1 && first < 0) begin
                first = i; fpc = pc_o; fir = ir_o;
            end
            run_cycle();
        end
        n_vec++;
        if (first != 3) begin
            n_err++;
            $display("FAIL first_valid_cycle got=%0d exp=3", first);
        end
        n_vec++;
        if (fpc !== RST_PC || fir !== mem_word(RST_PC)) begin
            n_err++;
            $display("FAIL first_instr got pc=%h ir=%h exp pc=%h ir=%h", fpc, fir, RST_PC, mem_word(RST_PC));
        end
    endtask

    task automatic test_backpressure();
        set_knobs(100, 0, 100, 1, 1);
        reset = 1'b0; idle_inputs();
        release_reset();
        repeat (6) run_cycle();
        n_vec++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'h0) begin
            n_err++;
            $display("FAIL full_stall got req=%b valid=%b pc=%h exp 0/1/00000000", imem_req_o, valid_o, pc_o);
        end
        rdy_pct = 100;
        run_cycle();
        n_vec++;
        if (pc_o !== 32'h4 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
            n_err++;
            $display("FAIL pop_resume got pc=%h req=%b addr=%h exp 00000004/1/00000008", pc_o, imem_req_o, imem_addr_o);
        end
        repeat (4) run_cycle();
    endtask

    task automatic test_redirect_flush();
        int flush_cycles = 0;
        bit seen_req = 1'b0, seen_valid = 1'b0;
        set_knobs(100, 100, 100, 3, 3);
        reset = 1'b0; idle_inputs();
        release_reset();
        repeat (3) run_cycle();
        n_vec++;
        if (imem_req_o !== 1'b0 || count_pend(1'b0) != 2) begin
            n_err++;
            $display("FAIL two_outstanding got req=%b owed=%0d exp 0/2", imem_req_o, count_pend(1'b0));
        end
        redir_now = 1'b1; redir_tgt = 32'h0000_0103;
        run_cycle();
        for (int i = 0; i < 10 && !seen_req; i++) begin
            if (imem_req_o === 1'b1) seen_req = 1'b1;
            else begin flush_cycles++; run_cycle(); end
        end
        n_vec++;
        if (!seen_req || imem_addr_o !== 32'h100 || flush_cycles != 2) begin
            n_err++;
            $display("FAIL flush_restart got seen=%b addr=%h flush_cycles=%0d exp 1/00000100/2",
                     seen_req, imem_addr_o, flush_cycles);
        end
        for (int i = 0; i < 10 && !seen_valid; i++) begin
            if (valid_o === 1'b1) seen_valid = 1'b1;
            else run_cycle();
        end
        n_vec++;
        if (!seen_valid || pc_o !== 32'h100) begin
            n_err++;
            $display("FAIL flush_first_valid got seen=%b pc=%h exp 1/00000100", seen_valid, pc_o);
        end
        repeat (4) run_cycle();
    endtask

    task automatic test_redirect_same_cycle();
        bit seen_valid = 1'b0;
        set_knobs(100, 0, 100, 1, 1);
        reset = 1'b0; idle_inputs();
        release_reset();
        repeat (2) run_cycle();
        n_vec++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || pend_q.size() != 1 || pend_q[0].due > cyc) begin
            n_err++;
            $display("FAIL collide_setup got req=%b addr=%h exp 1/00000004 with a response due", imem_req_o, imem_addr_o);
        end
        redir_now = 1'b1; redir_tgt = 32'h0000_0040;
        run_cycle();
        n_vec++;
        if (valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL collide_no_push got valid=%b exp 0", valid_o);
        end
        for (int i = 0; i < 10 && !seen_valid; i++) begin
            if (valid_o === 1'b1) seen_valid = 1'b1;
            else run_cycle();
        end
        n_vec++;
        if (!seen_valid || pc_o !== 32'h40 || ir_o !== mem_word(32'h40)) begin
            n_err++;
            $display("FAIL collide_first_valid got seen=%b pc=%h ir=%h exp 1/00000040/%h",
                     seen_valid, pc_o, ir_o, mem_word(32'h40));
        end
    endtask

    task automatic test_wrap();
        bit seen = 1'b0, done = 1'b0;
        set_knobs(100, 100, 100, 1, 1);
        reset = 1'b0; idle_inputs();
        release_reset();
        redir_now = 1'b1; redir_tgt = 32'hFFFF_FFF9;
        for (int i = 0; i < 14; i++) begin
            if (imem_req_o === 1'b1 && !done) begin
                if (seen) begin
                    done = 1'b1;
                    n_vec++;
                    if (imem_addr_o !== 32'h0) begin
                        n_err++;
                        $display("FAIL pc_wrap got addr=%h exp 00000000", imem_addr_o);
                    end
                end else if (imem_addr_o === 32'hFFFF_FFFC) seen = 1'b1;
            end
            run_cycle();
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL pc_wrap_timeout got seen=%b exp wrap observed", seen);
        end
    endtask

    task automatic test_reset_midstream();
        bit seen_valid = 1'b0;
        set_knobs(100, 0, 100, 1, 1);
        reset = 1'b0; idle_inputs();
        release_reset();
        repeat (6) run_cycle();
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (valid_o !== 1'b0 || ir_o !== NOP_W || imem_req_o !== 1'b0 || pc_o !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset got valid=%b ir=%h req=%b pc=%h exp 0/%h/0/0", valid_o, ir_o, imem_req_o, pc_o, NOP_W);
        end
        idle_inputs();
        release_reset();
        set_knobs(100, 100, 100, 1, 1);
        stray_pct = 100;
        run_cycle();
        n_vec++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC) begin
            n_err++;
            $display("FAIL restart_req got req=%b addr=%h exp 1/%h", imem_req_o, imem_addr_o, RST_PC);
        end
        run_cycle();
        stray_pct = 0;
        for (int i = 0; i < 10 && !seen_valid; i++) begin
            if (valid_o === 1'b1) seen_valid = 1'b1;
            else run_cycle();
        end
        n_vec++;
        if (!seen_valid || pc_o !== RST_PC || ir_o !== mem_word(RST_PC)) begin
            n_err++;
            $display("FAIL restart_first got seen=%b pc=%h ir=%h exp 1/%h/%h", seen_valid, pc_o, ir_o, RST_PC, mem_word(RST_PC));
        end
    endtask

    task automatic test_random();
        set_knobs(70, 60, 80, 1, 4);
        redir_pct = 4;
        stray_pct = 2;
        reset = 1'b0; idle_inputs();
        release_reset();
        repeat (3000) run_cycle();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
